// File: rtl/ntt_stage_sched_if.sv
// Scheduler <-> controller / address-generator bundle for the NTT stage scheduler.
interface ntt_stage_sched_if #(
    parameter int unsigned N_STAGES = 7,
    parameter int unsigned GROUPS   = 16
);
    localparam int unsigned GROUP_W = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int unsigned STAGE_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
    localparam int unsigned OLEN_W  = N_STAGES + 1;

    logic               start_i;
    logic               is_NTT;
    logic               busy_o;
    logic               issue_o;
    logic [GROUP_W-1:0] group_o;
    logic [STAGE_W-1:0] stage_o;
    logic [OLEN_W-1:0]  olen_o;
    logic               mode_o;
    logic               wb_en_o;
    logic               done_o;

    // Scheduler side
    modport master (
        input  start_i, is_NTT,
        output busy_o, issue_o, group_o, stage_o, olen_o, mode_o, wb_en_o, done_o
    );

    // Controller / consumer side
    modport slave (
        output start_i, is_NTT,
        input  busy_o, issue_o, group_o, stage_o, olen_o, mode_o, wb_en_o, done_o
    );
endinterface

// File: rtl/ntt_stage_sched.sv
// Stage scheduler for the 8-BU NTT/INTT core: issues GROUPS butterfly groups per
// layer, drains the read+BU pipeline for BU_LAT cycles, repeats for N_STAGES layers.
module ntt_stage_sched #(
    parameter int unsigned N_STAGES = 7,
    parameter int unsigned GROUPS   = 16,
    parameter int unsigned BU_LAT   = 6
) (
    input  logic                clk_i,
    input  logic                rst_i,
    ntt_stage_sched_if.master   bus
);
    localparam int unsigned GROUP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int unsigned STAGE_W  = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
    localparam int unsigned DRAIN_W  = (BU_LAT > 1) ? $clog2(BU_LAT) : 1;
    localparam int unsigned OLEN_W   = N_STAGES + 1;
    localparam int unsigned OLEN_MAX = 1 << N_STAGES;
    localparam int unsigned OLEN_MIN = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [GROUP_W-1:0] group_q;
    logic [DRAIN_W-1:0] drain_q;
    logic [STAGE_W-1:0] stage_q;
    logic [OLEN_W-1:0]  olen_q;
    logic               mode_q;
    logic               issue_q;
    logic               busy_q;
    logic               done_q;
    logic [BU_LAT-1:0]  wb_sr;

    // Layer sequencing FSM with registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            group_q <= '0;
            drain_q <= '0;
            stage_q <= '0;
            olen_q  <= '0;
            mode_q  <= 1'b0;
            issue_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start_i) begin
                        mode_q  <= bus.is_NTT;
                        stage_q <= '0;
                        group_q <= '0;
                        drain_q <= '0;
                        olen_q  <= bus.is_NTT ? OLEN_W'(OLEN_MAX) : OLEN_W'(OLEN_MIN);
                        issue_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (group_q == GROUP_W'(GROUPS - 1)) begin
                        group_q <= '0;
                        drain_q <= '0;
                        issue_q <= 1'b0;
                        state_q <= S_DRAIN;
                    end else begin
                        group_q <= group_q + GROUP_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (drain_q == DRAIN_W'(BU_LAT - 1)) begin
                        drain_q <= '0;
                        if (stage_q == STAGE_W'(N_STAGES - 1)) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            stage_q <= stage_q + STAGE_W'(1);
                            olen_q  <= mode_q ? (olen_q >> 1) : (olen_q << 1);
                            group_q <= '0;
                            issue_q <= 1'b1;
                            state_q <= S_ISSUE;
                        end
                    end else begin
                        drain_q <= drain_q + DRAIN_W'(1);
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Write-back enable: issue delayed exactly BU_LAT cycles
    if (BU_LAT == 1) begin : g_wb_one
        always_ff @(posedge clk_i) begin
            if (rst_i) wb_sr <= '0;
            else       wb_sr <= issue_q;
        end
    end else begin : g_wb_many
        always_ff @(posedge clk_i) begin
            if (rst_i) wb_sr <= '0;
            else       wb_sr <= {wb_sr[BU_LAT-2:0], issue_q};
        end
    end

    assign bus.busy_o  = busy_q;
    assign bus.issue_o = issue_q;
    assign bus.group_o = group_q;
    assign bus.stage_o = stage_q;
    assign bus.olen_o  = olen_q;
    assign bus.mode_o  = mode_q;
    assign bus.wb_en_o = wb_sr[BU_LAT-1];
    assign bus.done_o  = done_q;
endmodule

// File: tb/tb_ntt_stage_sched.sv
// Self-checking bench for ntt_stage_sched: reference timeline model + vector table.
module tb_ntt_stage_sched;
    localparam int NST  = 7;
    localparam int GRP  = 16;
    localparam int LAT  = 6;
    localparam int PER  = GRP + LAT;
    localparam int LAST = NST * PER;    // relative index of the done cycle

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ntt_stage_sched_if bus ();

    ntt_stage_sched dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;
    int n_issue;
    int n_wb;
    bit tbl_en = 1'b0;

    // Reference model: cycles since the first issue of the current transform (-1 = idle)
    int m_rel   = -1;
    int m_stage = 0;
    int m_olen  = 0;
    bit m_mode  = 1'b0;

    typedef struct {
        int cyc;
        bit issue;
        int group;   // -1: don't care
        int stage;
        int olen;
        bit wb;
        bit done;
        bit busy;
    } vec_t;
    vec_t vecs[10];

    function automatic void chk(string nm, logic [31:0] act, int exp);
        n_cmp++;
        if (act !== 32'(exp)) begin
            n_mis++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endfunction

    function automatic bit m_issue_at(int rel);
        return (rel >= 0) && (rel < LAST) && ((rel % PER) < GRP);
    endfunction

    function automatic void model_edge(bit st, bit nt, bit r);
        if (r) begin
            m_rel = -1; m_stage = 0; m_olen = 0; m_mode = 1'b0;
        end else if (m_rel < 0) begin
            if (st) begin
                m_rel  = 0;
                m_mode = nt;
            end
        end else if (m_rel == LAST) begin
            m_rel = -1;
        end else begin
            m_rel++;
        end
        if (m_rel >= 0 && m_rel < LAST) begin
            m_stage = m_rel / PER;
            m_olen  = m_mode ? ((1 << NST) >> m_stage) : (2 << m_stage);
        end
    endfunction

    function automatic void check_all();
        bit exp_issue;
        exp_issue = m_issue_at(m_rel);
        chk("busy",  bus.busy_o,  (m_rel >= 0));
        chk("issue", bus.issue_o, exp_issue);
        chk("wb_en", bus.wb_en_o, m_issue_at(m_rel - LAT));
        chk("done",  bus.done_o,  (m_rel == LAST));
        chk("stage", bus.stage_o, m_stage);
        chk("olen",  bus.olen_o,  m_olen);
        chk("mode",  bus.mode_o,  m_mode);
        if (exp_issue) chk("group", bus.group_o, m_rel % PER);
        if (m_rel >= 0)
            chk("olen_range", (bus.olen_o >= 2 && bus.olen_o <= 128), 1);
        n_issue += int'(bus.issue_o);
        n_wb    += int'(bus.wb_en_o);
    endfunction

    function automatic void check_vec(int k);
        chk("vec_issue", bus.issue_o, vecs[k].issue);
        if (vecs[k].group >= 0) chk("vec_group", bus.group_o, vecs[k].group);
        chk("vec_stage", bus.stage_o, vecs[k].stage);
        chk("vec_olen",  bus.olen_o,  vecs[k].olen);
        chk("vec_wb",    bus.wb_en_o, vecs[k].wb);
        chk("vec_done",  bus.done_o,  vecs[k].done);
        chk("vec_busy",  bus.busy_o,  vecs[k].busy);
    endfunction

    // Drive one cycle's inputs, advance the model at the edge, check at the falling edge
    task automatic step(input bit st, input bit nt, input bit r);
        bus.start_i = st;
        bus.is_NTT  = nt;
        rst         = r;
        @(posedge clk);
        model_edge(st, nt, r);
        @(negedge clk);
        cyc++;
        check_all();
        if (tbl_en)
            for (int k = 0; k < 10; k++)
                if (vecs[k].cyc == cyc) check_vec(k);
    endtask

    initial begin
        // Expected NTT timeline, start accepted in cycle 0
        vecs[0] = '{1,   1, 0,  0, 128, 0, 0, 1};
        vecs[1] = '{7,   1, 6,  0, 128, 1, 0, 1};
        vecs[2] = '{16,  1, 15, 0, 128, 1, 0, 1};
        vecs[3] = '{17,  0, -1, 0, 128, 1, 0, 1};
        vecs[4] = '{22,  0, -1, 0, 128, 1, 0, 1};
        vecs[5] = '{23,  1, 0,  1, 64,  0, 0, 1};
        vecs[6] = '{148, 1, 15, 6, 2,   1, 0, 1};
        vecs[7] = '{154, 0, -1, 6, 2,   1, 0, 1};
        vecs[8] = '{155, 0, -1, 6, 2,   0, 1, 1};
        vecs[9] = '{156, 0, -1, 6, 2,   0, 0, 0};

        // Reset held with start asserted: start lost, all outputs zero
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);

        // Forward NTT against the vector table
        cyc = 0; n_issue = 0; n_wb = 0; tbl_en = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        while (cyc < 156) step(1'b0, 1'(($urandom % 2)), 1'b0);
        tbl_en = 1'b0;
        chk("ntt_issue_count", n_issue, 112);
        chk("ntt_wb_count",    n_wb,    112);

        // Inverse NTT, is_NTT toggling while busy
        cyc = 0; n_issue = 0; n_wb = 0;
        step(1'b1, 1'b0, 1'b0);
        while (cyc < 156) begin
            if ((cyc - 1) % PER == 0 && cyc < 155)
                chk("intt_stage_olen", bus.olen_o, 2 << ((cyc - 1) / PER));
            step(1'b0, 1'(($urandom % 2)), 1'b0);
        end
        chk("intt_issue_count", n_issue, 112);
        chk("intt_wb_count",    n_wb,    112);

        // Start while busy ignored; start in the idle cycle accepted
        cyc = 0;
        step(1'b1, 1'b1, 1'b0);
        while (cyc < 156) step((cyc == 10 || cyc == 154), 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("restart_issue", bus.issue_o, 1);
        chk("restart_group", bus.group_o, 0);
        chk("restart_olen",  bus.olen_o,  2);
        while (cyc < 320) step(1'b0, 1'b0, 1'b0);

        // Reset mid-transform, then a fresh transform
        cyc = 0;
        step(1'b1, 1'b1, 1'b0);
        while (cyc < 40) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        chk("midrst_busy",  bus.busy_o,  0);
        chk("midrst_issue", bus.issue_o, 0);
        chk("midrst_olen",  bus.olen_o,  0);
        n_wb = 0; n_issue = 0;
        repeat (10) step(1'b0, 1'b1, 1'b0);
        chk("midrst_wb_after", n_wb, 0);
        cyc = 0;
        step(1'b1, 1'b1, 1'b0);
        while (cyc < 155) step(1'b0, 1'b1, 1'b0);
        chk("fresh_done", bus.done_o, 1);
        step(1'b0, 1'b1, 1'b0);

        // Randomized start / mode / reset traffic against the model
        repeat (3000) step(1'(($urandom % 6) == 0), 1'(($urandom % 2)), 1'(($urandom % 300) == 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
